// File: rtl/qd_pkg.sv
// Shared types, class tables and match rule for the 4-bit P/D code family.
package qd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } qd_gen_state_t;

  // Bit n holds the class of code n.
  localparam logic [15:0] QD_P_TABLE = 16'h066C;
  localparam logic [15:0] QD_D_TABLE = 16'h2525;

  function automatic logic qd_match(input logic [3:0] code,
                                    input logic [1:0] care,
                                    input logic [1:0] tgt);
    logic p;
    logic d;
    p = QD_P_TABLE[code];
    d = QD_D_TABLE[code];
    return (~care[1] | (p == tgt[1])) & (~care[0] | (d == tgt[0]));
  endfunction

endpackage

// File: rtl/qd_class_lut.sv
// Combinational code -> P/D class lookup from the shared tables.
module qd_class_lut
  import qd_pkg::*;
(
  input  logic [3:0] code_i,
  output logic       p_o,
  output logic       d_o
);

  assign p_o = QD_P_TABLE[code_i];
  assign d_o = QD_D_TABLE[code_i];

endmodule

// File: rtl/qd_code_gen.sv
// Sweeps codes 0..SWEEP_LAST and offers every code whose P/D class matches the target.
// Optional match counter output enabled by defining QD_CODE_GEN_CNT_EN.
module qd_code_gen
  import qd_pkg::*;
#(
  parameter int unsigned SWEEP_LAST = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] care,
  input  logic [1:0] tgt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] code,
  output logic       code_p,
  output logic       code_d,
  output logic       busy,
  output logic       done
`ifdef QD_CODE_GEN_CNT_EN
  ,
  output logic [4:0] match_cnt
`endif
);

  localparam logic [3:0] LAST = 4'(SWEEP_LAST);

  qd_gen_state_t state_q;
  logic [3:0]    cand_q;
  logic [1:0]    care_q;
  logic [1:0]    tgt_q;
  logic          out_valid_q;
  logic [3:0]    code_q;
  logic          code_p_q;
  logic          code_d_q;
  logic          done_q;

  logic lut_p;
  logic lut_d;
  logic cand_match;

  qd_class_lut u_lut (
    .code_i (cand_q),
    .p_o    (lut_p),
    .d_o    (lut_d)
  );

  assign cand_match = qd_match(cand_q, care_q, tgt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      care_q      <= 2'b00;
      tgt_q       <= 2'b00;
      out_valid_q <= 1'b0;
      code_q      <= 4'd0;
      code_p_q    <= 1'b0;
      code_d_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            care_q  <= care;
            tgt_q   <= tgt;
            cand_q  <= 4'd0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (cand_match) begin
            code_q      <= cand_q;
            code_p_q    <= lut_p;
            code_d_q    <= lut_d;
            out_valid_q <= 1'b1;
            state_q     <= OFFER;
          end else if (cand_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cand_q <= cand_q + 4'd1;
          end
        end
        OFFER: begin
          // Abort beats a coinciding handshake, so the last offer never yields done.
          if (abort) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            if (cand_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cand_q  <= cand_q + 4'd1;
              state_q <= SCAN;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign code_p    = code_p_q;
  assign code_d    = code_d_q;
  assign done      = done_q;
  assign busy      = (state_q == SCAN) || (state_q == OFFER);

`ifdef QD_CODE_GEN_CNT_EN
  logic [4:0] match_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_q <= 5'd0;
    end else if (state_q == IDLE && start && !abort) begin
      match_cnt_q <= 5'd0;
    end else if (state_q == OFFER && !abort && out_ready) begin
      match_cnt_q <= match_cnt_q + 5'd1;
    end
  end

  assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_qd_code_gen.sv
// Directed, table-driven bench for qd_code_gen (define QD_CODE_GEN_CNT_EN to also check match_cnt).
module tb_qd_code_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [1:0] care;
  logic [1:0] tgt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] code;
  logic       code_p;
  logic       code_d;
  logic       busy;
  logic       done;
`ifdef QD_CODE_GEN_CNT_EN
  logic [4:0] match_cnt;
`endif

  always #5 clk = ~clk;

  qd_code_gen #(.SWEEP_LAST(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .care      (care),
    .tgt       (tgt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code      (code),
    .code_p    (code_p),
    .code_d    (code_d),
    .busy      (busy),
    .done      (done)
`ifdef QD_CODE_GEN_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int ref_p(input int c);
    case (c)
      2, 3, 5, 6, 9, 10: return 1;
      default:           return 0;
    endcase
  endfunction

  function automatic int ref_d(input int c);
    case (c)
      0, 2, 5, 8, 10, 13: return 1;
      default:            return 0;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  care;
    logic [1:0]  tgt;
    int          period;   // out_ready high one cycle in every 'period'
    bit          noisy;    // keep start high and change care/tgt during the sweep
    logic [15:0] mask;     // hand-computed set of codes expected to be offered
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input string tag);
    int   exp_list[$];
    int   idx;
    int   cyc;
    int   last_hs;
    int   first_v;
    int   held;
    int   n_exp;
    logic prev_v;
    logic prev_hs;
    bit   fin;
    for (int c = 0; c < 16; c++) if (v.mask[c]) exp_list.push_back(c);
    n_exp = exp_list.size();
    @(negedge clk);
    care = v.care; tgt = v.tgt; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    if (v.noisy) begin
      care = 2'b00; tgt = 2'b00;
    end else begin
      start = 1'b0;
    end
    check({tag, " busy after start"}, int'(busy), 1);
    idx = 0; cyc = 0; last_hs = -1; first_v = -1; held = 0;
    prev_v = 1'b0; prev_hs = 1'b0; fin = 1'b0;
    while (!fin && cyc < 200) begin
      if (done) begin
        fin = 1'b1;
        start = 1'b0; out_ready = 1'b0;
        check({tag, " offers"}, idx, n_exp);
        if (n_exp > 0) begin
          check({tag, " done latency"}, cyc - last_hs, 16 - exp_list[n_exp-1]);
          check({tag, " first offer cycle"}, first_v, exp_list[0] + 1);
        end
`ifdef QD_CODE_GEN_CNT_EN
        check({tag, " match_cnt"}, int'(match_cnt), n_exp);
`endif
      end else begin
        if (prev_v && !prev_hs && !out_valid)
          check({tag, " valid dropped in stall"}, 0, 1);
        if (out_valid) begin
          if (first_v < 0) first_v = cyc;
          if (prev_v && !prev_hs) begin
            check({tag, " stall hold code"}, int'(code), held);
          end else begin
            if (idx < n_exp) begin
              check({tag, " code"}, int'(code), exp_list[idx]);
              check({tag, " code_p"}, int'(code_p), ref_p(exp_list[idx]));
              check({tag, " code_d"}, int'(code_d), ref_d(exp_list[idx]));
            end else begin
              check({tag, " extra offer"}, int'(code), -1);
            end
            held = int'(code);
          end
        end
        out_ready = ((cyc % v.period) == v.period - 1);
        prev_hs = out_valid && out_ready;
        if (prev_hs) begin
          idx++;
          last_hs = cyc;
        end
        prev_v = out_valid;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) check({tag, " timeout waiting for done"}, 0, 1);
    @(negedge clk);
    check({tag, " done one cycle"}, int'(done), 0);
    check({tag, " busy after done"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{care: 2'b11, tgt: 2'b11, period: 1, noisy: 1'b0, mask: 16'h0424};
    vecs[1] = '{care: 2'b11, tgt: 2'b00, period: 1, noisy: 1'b0, mask: 16'hD892};
    vecs[2] = '{care: 2'b10, tgt: 2'b10, period: 3, noisy: 1'b1, mask: 16'h066C};
    vecs[3] = '{care: 2'b00, tgt: 2'b00, period: 1, noisy: 1'b0, mask: 16'hFFFF};
    vecs[4] = '{care: 2'b01, tgt: 2'b01, period: 2, noisy: 1'b0, mask: 16'h2525};
    vecs[5] = '{care: 2'b10, tgt: 2'b00, period: 1, noisy: 1'b0, mask: 16'hF993};

    rst = 1'b1; start = 1'b0; abort = 1'b0; care = 2'b00; tgt = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset code", int'(code), 0);
    rst = 1'b0;

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1; abort = 1'b1; care = 2'b00;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start+abort idle busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset while a code is being offered
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      care = 2'b11; tgt = 2'b11; start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (out_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check("rst-offer reached offer", int'(seen), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst-offer out_valid", int'(out_valid), 0);
      check("rst-offer busy", int'(busy), 0);
      check("rst-offer code", int'(code), 0);
      check("rst-offer done", int'(done), 0);
    end

    // abort while code 0 is offered, then a fresh sweep
    begin
      bit seen;
      bit any_done;
      seen = 1'b0; any_done = 1'b0;
      @(negedge clk);
      care = 2'b01; tgt = 2'b11; start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (out_valid) seen = 1'b1;
        else @(negedge clk);
      end
      check("abort reached offer", int'(seen), 1);
      check("abort offered code", int'(code), 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort out_valid", int'(out_valid), 0);
      check("abort busy", int'(busy), 0);
      for (int k = 0; k < 4; k++) begin
        if (done) any_done = 1'b1;
        @(negedge clk);
      end
      check("abort no done", int'(any_done), 0);
      run_vec(vecs[0], "after-abort");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/qd_code_gen.md
Name: qd_code_gen

Overview:
- Sequential generator that is the producer side of the team's 4-bit P/D code classification.
- On request, it sweeps codes 0..15 in ascending order, one candidate per clock.
- Every code whose P/D classification matches the requested target is offered on a valid/ready output port.
- Feeds stimulus and code-table traffic to downstream classifier and test logic.

Parameters:
- SWEEP_LAST, 15, last candidate code of a sweep. Legal range 1..15; the sweep always starts at 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  1-cycle request; sampled only in IDLE
- abort  in  1  cancels the current sweep
- care  in  2  bit1: P is compared, bit0: D is compared; latched on start
- tgt  in  2  bit1: required P, bit0: required D; latched on start
- out_valid  out  1  code is being offered
- out_ready  in  1  consumer accepts the code
- code  out  4  offered code
- code_p  out  1  P class of code
- code_d  out  1  D class of code
- busy  out  1  high in SCAN or OFFER
- done  out  1  1-cycle pulse when a sweep completes

Behaviour:
- Class tables:
  - P=1 for codes {2,3,5,6,9,10}.
  - D=1 for codes {0,2,5,8,10,13}.
  - All other codes are 0 in the respective table.
- Match rule: match = (~care[1] | (P==tgt[1])) & (~care[0] | (D==tgt[0])).
- Reset: state=IDLE, cand=0, all outputs 0. rst takes priority over start and abort.
- FSM states: IDLE, SCAN, OFFER, DONE.
  - IDLE: when start=1, latch care/tgt, set cand<=0, go to SCAN. busy rises on the next cycle.
  - SCAN: evaluate cand in the current cycle.
    - Match: register code/code_p/code_d and set out_valid<=1; go to OFFER.
    - No match and cand==SWEEP_LAST: go to DONE.
    - Otherwise: cand<=cand+1.
  - OFFER: out_valid, code, code_p and code_d are held stable until a handshake (out_valid & out_ready).
    - On handshake: out_valid<=0. If cand==SWEEP_LAST go to DONE; else cand<=cand+1 and go to SCAN.
  - DONE: done=1 for exactly 1 cycle, then IDLE.
- Latency: start accepted at cycle t, cand 0 evaluated at t+1, first out_valid visible at t+2 when code 0 matches.
- Throughput: each accepted code costs 2 cycles (OFFER plus the following SCAN slot); each rejected code costs 1 cycle.
- Wrap: cand never exceeds SWEEP_LAST. There is no wrap to 0 within a sweep.
- start while busy or in DONE: ignored; care/tgt are not re-latched.
- abort in SCAN, OFFER or DONE: next state IDLE; out_valid and done are 0 the next cycle. No done pulse is produced, even if abort coincides with the final handshake.
- abort and start together in IDLE: abort wins and start is ignored.
- out_ready while out_valid=0: no effect.
- care=00: every code matches, giving SWEEP_LAST+1 offers.

Optional Feature:
- Macro QD_CODE_GEN_CNT_EN.
- When defined, add output match_cnt (5 bits):
  - cleared to 0 when start is accepted;
  - incremented on each handshake;
  - held after DONE until the next accepted start;
  - reset value 0; unchanged by abort.
- When not defined, the port and its counter are absent and all other behaviour is identical.

Decomposition:
- Package qd_pkg holds:
  - state enum qd_gen_state_t {IDLE,SCAN,OFFER,DONE};
  - 16-bit constants QD_P_TABLE=16'h066C and QD_D_TABLE=16'h2525 (bit n = class of code n);
  - function qd_match(code, care, tgt).
- One natural sub-module: qd_class_lut, a combinational lookup of code to P/D bits from the package tables.
- FSM, candidate counter and output registers stay in the top module.

Test Plan:
- Reset mid-OFFER (care=11, tgt=11, out_ready=0, rst held 1 cycle while out_valid=1) -> next cycle out_valid=0, busy=0, code=0, done=0.
- care=11, tgt=11, out_ready=1 -> codes 2,5,10 offered in order, each with code_p=1 and code_d=1; done pulse 1 cycle after the final sweep step; busy low afterwards.
- care=11, tgt=00, out_ready=1 -> codes 1,4,7,11,12,14,15. Because 15 matches, DONE is entered straight from the OFFER handshake.
- care=10, tgt=10, out_ready toggling 1-in-3 -> codes 2,3,5,6,9,10 in order; each code and out_valid held stable across every stall; no code dropped or duplicated.
- care=00, out_ready=1 -> 16 offers (0..15); done exactly 1 cycle; with QD_CODE_GEN_CNT_EN, match_cnt=16.
- care=01, tgt=11 (D=1 only), out_ready=0; abort asserted while code=0 is offered -> out_valid=0 next cycle, no done, IDLE. A new start (care=11, tgt=11) then yields first code 2.
